// File: rtl/ctrl_pipe.sv
// Clocked emulation of a Muller-C micropipeline: DEPTH C-element control stages,
// each gating a WIDTH-bit bundled-data register, running a 2- or 4-phase req/ack protocol.
module ctrl_pipe #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int PHASES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  output logic             ack_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic [WIDTH-1:0] data_out,
  output logic [DEPTH-1:0] ctrl_out,
  output logic             busy
);

  logic [DEPTH-1:0]            c, prv, nxt, link;
  logic [DEPTH-1:0][WIDTH-1:0] d, din;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic c_next, cap;

    if (gi == 0) begin : g_head
      assign prv[gi] = req_in;
      assign din[gi] = data_in;
    end else begin : g_body
      assign prv[gi] = c[gi-1];
      assign din[gi] = d[gi-1];
    end

    // link[] flags a stage whose handshake with its successor is still open
    if (gi == DEPTH-1) begin : g_tail
      assign nxt[gi]  = ack_out;
      assign link[gi] = (PHASES == 4) ? (c[gi] | ack_out) : (c[gi] ^ ack_out);
    end else begin : g_mid
      assign nxt[gi]  = c[gi+1];
      assign link[gi] = c[gi] ^ c[gi+1];
    end

    // 4-phase moves data only on the rising control edge; RTZ phase is data-silent
    always_comb begin
      c_next = (prv[gi] == ~nxt[gi]) ? prv[gi] : c[gi];
      cap    = (c_next != c[gi]) && ((PHASES == 2) || c_next);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        c[gi] <= 1'b0;
        d[gi] <= '0;
      end else begin
        c[gi] <= c_next;
        if (cap) d[gi] <= din[gi];
      end
    end
  end

  assign ack_in   = c[0];
  assign req_out  = c[DEPTH-1];
  assign ctrl_out = c;
  assign data_out = d[DEPTH-1];
  assign busy     = |link;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed protocol scenarios on three configurations plus
// randomized req/ack traffic checked against a token-order scoreboard.
module tb_ctrl_pipe;
  logic            clk, rst;
  logic [2:0]      req_in, ack_out;
  logic [2:0][7:0] data_in;
  wire  [2:0]      ack_in, req_out, busy;
  wire  [2:0][7:0] data_out;
  wire  [3:0]      ctrl_a, ctrl_b;
  wire             ctrl_c;
  int              vectors = 0, miscompares = 0;
  logic [7:0]      got[$];
  logic [7:0]      tok4[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  ctrl_pipe #(.WIDTH(8), .DEPTH(4), .PHASES(4)) u_p4 (
    .clk(clk), .rst(rst), .req_in(req_in[0]), .ack_in(ack_in[0]), .data_in(data_in[0]),
    .req_out(req_out[0]), .ack_out(ack_out[0]), .data_out(data_out[0]), .ctrl_out(ctrl_a), .busy(busy[0]));
  ctrl_pipe #(.WIDTH(8), .DEPTH(4), .PHASES(2)) u_p2 (
    .clk(clk), .rst(rst), .req_in(req_in[1]), .ack_in(ack_in[1]), .data_in(data_in[1]),
    .req_out(req_out[1]), .ack_out(ack_out[1]), .data_out(data_out[1]), .ctrl_out(ctrl_b), .busy(busy[1]));
  ctrl_pipe #(.WIDTH(8), .DEPTH(1), .PHASES(4)) u_d1 (
    .clk(clk), .rst(rst), .req_in(req_in[2]), .ack_in(ack_in[2]), .data_in(data_in[2]),
    .req_out(req_out[2]), .ack_out(ack_out[2]), .data_out(data_out[2]), .ctrl_out(ctrl_c), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, required finish within time limit");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ctrl_of(input int u);
    return (u == 0) ? ctrl_a : (u == 1) ? ctrl_b : {3'b000, ctrl_c};
  endfunction

  task automatic wait_ack(input int u, input logic v, input string tag);
    int n = 0;
    while (ack_in[u] !== v && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(ack_in[u]), 32'(v));
  endtask

  // Sender/receiver agents obeying the handshake; every delivered token must
  // match the oldest outstanding one, and nothing may be lost or invented.
  task automatic run_random(input int u, input bit p2, input int ntok);
    logic [7:0] q[$];
    logic [7:0] v;
    int sent = 0, rcvd = 0, cyc = 0, settle = 0;
    while ((rcvd < ntok || settle < 30) && cyc < 8000) begin
      if (p2) begin
        if (req_in[u] == ack_in[u] && sent < ntok && $urandom_range(0, 2) == 0) begin
          v = 8'($urandom); data_in[u] = v; q.push_back(v); req_in[u] = ~req_in[u]; sent++;
        end
        if (req_out[u] != ack_out[u] && $urandom_range(0, 3) != 0) begin
          chk("rand_data", 32'(data_out[u]), (q.size() != 0) ? 32'(q.pop_front()) : 32'hDEAD_BEEF);
          ack_out[u] = req_out[u]; rcvd++;
        end
      end else begin
        if (!req_in[u] && !ack_in[u] && sent < ntok && $urandom_range(0, 2) == 0) begin
          v = 8'($urandom); data_in[u] = v; q.push_back(v); req_in[u] = 1'b1; sent++;
        end else if (req_in[u] && ack_in[u] && $urandom_range(0, 1) == 0)
          req_in[u] = 1'b0;
        if (req_out[u] && !ack_out[u] && $urandom_range(0, 4) == 0) begin
          chk("rand_data", 32'(data_out[u]), (q.size() != 0) ? 32'(q.pop_front()) : 32'hDEAD_BEEF);
          ack_out[u] = 1'b1; rcvd++;
        end else if (!req_out[u] && ack_out[u] && $urandom_range(0, 1) == 0)
          ack_out[u] = 1'b0;
      end
      if (rcvd >= ntok) settle++;
      tick();
      cyc++;
    end
    chk("rand_count", 32'(rcvd), 32'(ntok));
    chk("rand_leftover", 32'(q.size()), 32'd0);
    chk("rand_idle_busy", 32'(busy[u]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_in = 3'($urandom); ack_out = 3'($urandom); data_in = '0;
    for (int u = 0; u < 3; u++) data_in[u] = 8'($urandom);
    // T1: reset with random inputs; ack_out settled low so busy reads its reset meaning
    tick();
    req_in = 3'($urandom); ack_out = 3'b000;
    tick();
    for (int u = 0; u < 3; u++) begin
      chk("t1_ack_in", 32'(ack_in[u]), 32'd0);
      chk("t1_req_out", 32'(req_out[u]), 32'd0);
      chk("t1_ctrl", 32'(ctrl_of(u)), 32'd0);
      chk("t1_data_out", 32'(data_out[u]), 32'h00);
      chk("t1_busy", 32'(busy[u]), 32'd0);
    end
    rst = 1'b0; req_in = 3'b000; ack_out = 3'b000;
    tick();

    // T2: 4-phase latency, then return-to-zero
    data_in[0] = 8'hA5; req_in[0] = 1'b1;
    tick();
    chk("t2_ack_k1", 32'(ack_in[0]), 32'd1);
    chk("t2_ctrl_k1", 32'(ctrl_a), 32'h1);
    chk("t2_busy", 32'(busy[0]), 32'd1);
    tick(); tick();
    chk("t2_req_k3", 32'(req_out[0]), 32'd0);
    tick();
    chk("t2_req_k4", 32'(req_out[0]), 32'd1);
    chk("t2_data_k4", 32'(data_out[0]), 32'hA5);
    chk("t2_ctrl_full", 32'(ctrl_a), 32'hF);
    ack_out[0] = 1'b1; req_in[0] = 1'b0;
    tick();
    chk("t2_ack_fall", 32'(ack_in[0]), 32'd0);
    tick(); tick();
    chk("t2_req_hold", 32'(req_out[0]), 32'd1);
    tick();
    chk("t2_req_fall", 32'(req_out[0]), 32'd0);
    chk("t2_data_keep", 32'(data_out[0]), 32'hA5);
    chk("t2_busy_ack", 32'(busy[0]), 32'd1);

    // T3: backpressure (ack_out held high), two tokens fill a DEPTH=4 pipe
    data_in[0] = 8'h3C; req_in[0] = 1'b1;
    wait_ack(0, 1'b1, "t3_ack1_up");
    req_in[0] = 1'b0;
    wait_ack(0, 1'b0, "t3_ack1_dn");
    data_in[0] = 8'h5A; req_in[0] = 1'b1;
    wait_ack(0, 1'b1, "t3_ack2_up");
    req_in[0] = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("t3_ack_stuck", 32'(ack_in[0]), 32'd1);
      chk("t3_req_held", 32'(req_out[0]), 32'd0);
      chk("t3_data_held", 32'(data_out[0]), 32'hA5);
    end
    chk("t3_ctrl_full", 32'(ctrl_a), 32'h5);
    got.delete();
    for (int n = 0; n < 40; n++) begin
      if (req_out[0] && !ack_out[0]) begin got.push_back(data_out[0]); ack_out[0] = 1'b1; end
      else if (!req_out[0] && ack_out[0]) ack_out[0] = 1'b0;
      tick();
    end
    chk("t3_count", 32'(got.size()), 32'd2);
    chk("t3_first", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD_BEEF, 32'h3C);
    chk("t3_second", (got.size() > 1) ? 32'(got[1]) : 32'hDEAD_BEEF, 32'h5A);
    chk("t3_ack_idle", 32'(ack_in[0]), 32'd0);
    chk("t3_busy_idle", 32'(busy[0]), 32'd0);

    // T4: 2-phase, receiver mirrors req_out
    got.delete();
    begin
      int k = 0;
      for (int n = 0; n < 60; n++) begin
        if (req_in[1] == ack_in[1] && k < 4) begin data_in[1] = tok4[k]; req_in[1] = ~req_in[1]; k++; end
        if (req_out[1] != ack_out[1]) begin got.push_back(data_out[1]); ack_out[1] = req_out[1]; end
        tick();
      end
    end
    chk("t4_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t4_data", (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(tok4[i]));
    chk("t4_req_level", 32'(req_out[1]), 32'd0);
    chk("t4_busy_idle", 32'(busy[1]), 32'd0);

    // T5: reset with two tokens in flight, then a fresh token at full latency
    ack_out[0] = 1'b1;
    data_in[0] = 8'h12; req_in[0] = 1'b1;
    wait_ack(0, 1'b1, "t5_ack1_up");
    req_in[0] = 1'b0;
    wait_ack(0, 1'b0, "t5_ack1_dn");
    data_in[0] = 8'h34; req_in[0] = 1'b1;
    wait_ack(0, 1'b1, "t5_ack2_up");
    chk("t5_loaded", 32'(ctrl_a), 32'h5);
    rst = 1'b1; req_in[0] = 1'b0; ack_out[0] = 1'b0;
    tick();
    chk("t5_ack_in", 32'(ack_in[0]), 32'd0);
    chk("t5_req_out", 32'(req_out[0]), 32'd0);
    chk("t5_ctrl", 32'(ctrl_a), 32'd0);
    chk("t5_data_out", 32'(data_out[0]), 32'd0);
    chk("t5_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0; data_in[0] = 8'h77; req_in[0] = 1'b1;
    tick();
    chk("t5_ack_k1", 32'(ack_in[0]), 32'd1);
    tick(); tick();
    chk("t5_req_k3", 32'(req_out[0]), 32'd0);
    tick();
    chk("t5_req_k4", 32'(req_out[0]), 32'd1);
    chk("t5_data_k4", 32'(data_out[0]), 32'h77);
    ack_out[0] = 1'b1; req_in[0] = 1'b0;
    repeat (4) tick();
    chk("t5_req_fall", 32'(req_out[0]), 32'd0);
    ack_out[0] = 1'b0;
    tick();
    chk("t5_busy_idle", 32'(busy[0]), 32'd0);

    // T6: DEPTH=1
    data_in[2] = 8'h0F; req_in[2] = 1'b1;
    tick();
    chk("t6_ack_k1", 32'(ack_in[2]), 32'd1);
    chk("t6_req_k1", 32'(req_out[2]), 32'd1);
    chk("t6_data_k1", 32'(data_out[2]), 32'h0F);
    chk("t6_ctrl", 32'(ctrl_of(2)), 32'd1);
    ack_out[2] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t6_hold", 32'(req_out[2]), 32'd1);
    end
    req_in[2] = 1'b0;
    tick();
    chk("t6_req_fall", 32'(req_out[2]), 32'd0);
    chk("t6_data_keep", 32'(data_out[2]), 32'h0F);
    ack_out[2] = 1'b0;
    tick();
    chk("t6_busy_idle", 32'(busy[2]), 32'd0);

    // randomized traffic on every configuration
    run_random(0, 1'b0, 30);
    run_random(1, 1'b1, 30);
    run_random(2, 1'b0, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
